datamem_arbiter: RTL and testbench



---
 rtl/datamem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_datamem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Round-robin arbiter and access sequencer that shares the
//            single-ported 32-word data memory between the CPU load/store
//            port (port 0) and the debug/loader port (port 1). Each accepted
//            request becomes one memory cycle followed by a one-cycle
//            response. Misaligned and out-of-range addresses are rejected
//            without touching the memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock          in   system clock, rising-edge active
//   reset          in   synchronous, active-high reset
//   req0/req1      in   access request, held until acknowledged
//   we0/we1        in   1 = store, 0 = load
//   addr0/addr1    in   byte address [ADDR_W-1:0]
//   wdata0/wdata1  in   store data [31:0]
//   ack0/ack1      out  one-cycle pulse, request accepted this cycle
//   rvalid0/1      out  one-cycle pulse, response complete
//   err0/err1      out  address fault flag, qualified by rvalid
//   rdata          out  load data, valid with rvalid
//   mem_address    out  datamem address
//   mem_writeData  out  datamem write data
//   mem_memWrite   out  datamem write strobe
//   mem_memRead    out  datamem read strobe
//   mem_readData   in   datamem read data (combinational)
// ============================================================================
module datamem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [31:0]       mem_readData
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_last;     // port granted most recently
  logic              r_port;     // port owning the access in flight
  logic              r_we;
  logic              r_fault;
  logic [ADDR_W-1:0] r_addr;     // doubles as the held memory address
  logic [31:0]       r_wdata;    // doubles as the held memory write data
  logic [31:0]       r_rdata;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              w_run;
  logic              w_inIdle;
  logic              w_inAccess;
  logic              w_inResp;
  logic              w_anyReq;
  logic              w_grantPort;
  logic              w_selWe;
  logic [ADDR_W-1:0] w_selAddr;
  logic [31:0]       w_selWdata;
  logic              w_selFault;
  logic [31:0]       w_memAddr;

  // An address faults when it is not word aligned or when any bit above the
  // word index is set, i.e. it falls outside the 2**DEPTH_LOG2-word memory.
  function automatic logic isFault(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] upper;
    upper   = a >> (DEPTH_LOG2 + 2);
    isFault = (a[1:0] != 2'b00) || (upper != '0);
  endfunction

  // Reset qualifies every strobe so that a reset arriving in ACCESS or RESP
  // suppresses the memory strobe and the response pulse in that same cycle.
  assign w_run      = !reset;
  assign w_inIdle   = (r_state == c_IDLE);
  assign w_inAccess = (r_state == c_ACCESS);
  assign w_inResp   = (r_state == c_RESP);
  assign w_anyReq   = req0 | req1;

  // Round robin: on a tie the port that did not win last time is chosen;
  // a lone request always wins regardless of the pointer.
  always_comb begin
    w_grantPort = 1'b0;
    if (req0 && req1) begin
      w_grantPort = ~r_last;
    end else if (req1) begin
      w_grantPort = 1'b1;
    end
  end

  assign w_selWe    = w_grantPort ? we1    : we0;
  assign w_selAddr  = w_grantPort ? addr1  : addr0;
  assign w_selWdata = w_grantPort ? wdata1 : wdata0;
  assign w_selFault = isFault(w_selAddr);

  // Fit the requester address to the 32-bit memory address bus.
  generate
    if (ADDR_W >= 32) begin : g_addrTrunc
      assign w_memAddr = r_addr[31:0];
    end else begin : g_addrPad
      assign w_memAddr = {{(32-ADDR_W){1'b0}}, r_addr};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_last  <= 1'b1;   // port 0 wins the first tie
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_anyReq) begin
            r_port  <= w_grantPort;
            r_last  <= w_grantPort;
            r_we    <= w_selWe;
            r_addr  <= w_selAddr;
            r_wdata <= w_selWdata;
            r_fault <= w_selFault;
            r_state <= c_ACCESS;
          end
        end
        c_ACCESS: begin
          // Stores and faulted accesses return zero data.
          if (!r_we && !r_fault) begin
            r_rdata <= mem_readData;
          end else begin
            r_rdata <= '0;
          end
          r_state <= c_RESP;
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ack0 = w_run & w_inIdle & w_anyReq & ~w_grantPort;
  assign ack1 = w_run & w_inIdle & w_anyReq &  w_grantPort;

  assign rvalid0 = w_run & w_inResp & ~r_port;
  assign rvalid1 = w_run & w_inResp &  r_port;
  assign err0    = rvalid0 & r_fault;
  assign err1    = rvalid1 & r_fault;
  assign rdata   = r_rdata;

  // Address and write data are registers loaded at grant time, so they show
  // the latched values during ACCESS and hold them until the next grant.
  assign mem_address   = w_memAddr;
  assign mem_writeData = r_wdata;
  assign mem_memWrite  = w_run & w_inAccess &  r_we & ~r_fault;
  assign mem_memRead   = w_run & w_inAccess & ~r_we & ~r_fault;

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_arbiter
// Purpose  : Self-checking bench for datamem_arbiter with a behavioural
//            word memory attached to the memory port and a transaction-level
//            reference model of arbitration and memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata, mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  datamem_arbiter #(.ADDR_W(32), .DEPTH_LOG2(5)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData)
  );

  function automatic logic [31:0] initWord(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Attached data memory: combinational read, write on the rising edge,
  // reloaded with a known pattern while reset is held.
  logic [31:0] dmem [32];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) dmem[i] <= initWord(i);
    end else if (mem_memWrite) begin
      dmem[mem_address[6:2]] <= mem_writeData;
    end
  end
  assign mem_readData = dmem[mem_address[6:2]];

  // Reference model state
  logic [31:0] refMem [32];
  bit          refLast;

  // Per-port stimulus
  bit          pWe    [2];
  logic [31:0] pAddr  [2];
  logic [31:0] pWdata [2];
  bit          pend   [2];

  task automatic modelReset();
    for (int i = 0; i < 32; i++) refMem[i] = initWord(i);
    refLast = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    req0 = pend[0]; we0 = pWe[0]; addr0 = pAddr[0]; wdata0 = pWdata[0];
    req1 = pend[1]; we1 = pWe[1]; addr1 = pAddr[1]; wdata1 = pWdata[1];
  endtask

  task automatic checkResetOutputs();
    chk("rst_ack",    {30'b0, ack0, ack1}, 32'd0);
    chk("rst_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
    chk("rst_err",    {30'b0, err0, err1}, 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_maddr",  mem_address, 32'd0);
    chk("rst_mwdata", mem_writeData, 32'd0);
    chk("rst_strobe", {30'b0, mem_memWrite, mem_memRead}, 32'd0);
  endtask

  task automatic applyReset();
    @(posedge clock); #1;
    reset = 1'b1; pend[0] = 0; pend[1] = 0; driveInputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    modelReset();
    @(negedge clock);
    checkResetOutputs();
  endtask

  task automatic setPort(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    pWe[p] = we; pAddr[p] = a; pWdata[p] = d;
  endtask

  // Raise the selected requests and service them until every one has been
  // accepted, checking ack, strobes and response cycle by cycle.
  task automatic runRound(input bit r0, input bit r1);
    int          g;
    bit          fault;
    logic [31:0] expRdata;
    pend[0] = r0; pend[1] = r1;
    for (int k = 0; k < 2; k++) begin
      if (pend[0] || pend[1]) begin
        @(posedge clock); #1; driveInputs();
        @(negedge clock);
        g = (pend[0] && pend[1]) ? int'(!refLast) : (pend[1] ? 1 : 0);
        chk("ack0",        32'(ack0), 32'(g == 0));
        chk("ack1",        32'(ack1), 32'(g == 1));
        chk("idle_rvalid", {30'b0, rvalid0, rvalid1}, 32'd0);
        chk("idle_strobe", {30'b0, mem_memWrite, mem_memRead}, 32'd0);
        refLast = (g == 1);
        pend[g] = 0;
        fault = (pAddr[g] % 4 != 0) || (pAddr[g] >= 32'd128);

        @(posedge clock); #1; driveInputs();
        @(negedge clock);
        chk("acc_memWrite", 32'(mem_memWrite), 32'(pWe[g] && !fault));
        chk("acc_memRead",  32'(mem_memRead),  32'(!pWe[g] && !fault));
        chk("acc_ack",      {30'b0, ack0, ack1}, 32'd0);
        chk("acc_addr",     mem_address, pAddr[g]);
        chk("acc_wdata",    mem_writeData, pWdata[g]);

        @(posedge clock); #1;
        @(negedge clock);
        expRdata = (!pWe[g] && !fault) ? refMem[pAddr[g][6:2]] : 32'd0;
        if (pWe[g] && !fault) refMem[pAddr[g][6:2]] = pWdata[g];
        chk("rvalid0", 32'(rvalid0), 32'(g == 0));
        chk("rvalid1", 32'(rvalid1), 32'(g == 1));
        chk("err0",    32'(err0), 32'(g == 0 && fault));
        chk("err1",    32'(err1), 32'(g == 1 && fault));
        chk("rdata",   rdata, expRdata);
        chk("resp_strobe", {30'b0, mem_memWrite, mem_memRead}, 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    int unsigned u;
    u = $urandom_range(0, 7);
    a = 32'($urandom_range(0, 31)) * 32'd4;
    if (u == 0)      a = a + 32'($urandom_range(1, 3));
    else if (u == 1) a = a | (32'd1 << $urandom_range(7, 31));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      pWe[p] = 0; pAddr[p] = '0; pWdata[p] = '0; pend[p] = 0;
    end
    modelReset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkResetOutputs();

    // Store then load on port 0
    setPort(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    runRound(1'b1, 1'b0);
    setPort(0, 1'b0, 32'h0000_0010, 32'h0);
    runRound(1'b1, 1'b0);
    chk("load_deadbeef", rdata, 32'hDEAD_BEEF);

    // Tie on the first request after reset: port 0 first
    applyReset();
    setPort(0, 1'b1, 32'h0000_0020, 32'h1111_2222);
    setPort(1, 1'b0, 32'h0000_0024, 32'h0);
    runRound(1'b1, 1'b1);

    // Sustained contention for 12 cycles: 0,1,0,1
    setPort(0, 1'b0, 32'h0000_0020, 32'h0);
    setPort(1, 1'b1, 32'h0000_0030, 32'h3333_4444);
    runRound(1'b1, 1'b1);
    setPort(0, 1'b0, 32'h0000_0030, 32'h0);
    setPort(1, 1'b0, 32'h0000_0008, 32'h0);
    runRound(1'b1, 1'b1);

    // Misaligned store on port 1, then load the neighbouring word
    setPort(1, 1'b1, 32'h0000_0006, 32'hBAD0_BAD0);
    runRound(1'b0, 1'b1);
    setPort(1, 1'b0, 32'h0000_0004, 32'h0);
    runRound(1'b0, 1'b1);
    chk("misaligned_prior", rdata, initWord(1));

    // Out-of-range load on port 0
    setPort(0, 1'b0, 32'h0000_0080, 32'h0);
    runRound(1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned mask;
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++)
        setPort(p, 1'($urandom_range(0, 1)), randAddr(), $urandom());
      runRound(mask[0], mask[1]);
    end

    // Reset during RESP of a port 1 load
    setPort(1, 1'b0, 32'h0000_000C, 32'h0);
    pend[0] = 0; pend[1] = 1;
    @(posedge clock); #1; driveInputs();
    @(negedge clock);
    chk("mid_ack1", 32'(ack1), 32'd1);
    pend[1] = 0;
    @(posedge clock); #1; driveInputs();
    @(negedge clock);
    chk("mid_memRead", 32'(mem_memRead), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("mid_rvalid1", 32'(rvalid1), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    modelReset();
    @(negedge clock);
    checkResetOutputs();
    setPort(1, 1'b0, 32'h0000_000C, 32'h0);
    runRound(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
